udp_port_dispatcher: RTL

//  Configurable UDP receive dispatcher between the IP parser and per-application consumers.
//  - Parses the 8-byte UDP header from the IP payload byte stream.
//  - Matches the destination port against a runtime-writable port table.
//  - Steers the payload to one of N_CH channels; drops and counts unmatched or malformed frames.

---
 rtl/eth_pkg.sv | 18 +
 rtl/udp_port_dispatcher_table.sv | 44 ++++
 rtl/udp_port_dispatcher.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/UDP receive-path types and constants.
// Used by the UDP dispatcher and its port table.
package eth_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] port_t;

  localparam int UDP_HDR_LEN = 8;
  localparam int UDP_DST_MSB = 2;
  localparam int UDP_LEN_MSB = 4;

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    DROP
  } udp_disp_state_t;

endpackage

// File: rtl/udp_port_dispatcher_table.sv
// Runtime-writable UDP destination port table.
// Lowest enabled matching entry wins.
module udp_port_table
  import eth_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  port_t            i_wport,
  input  logic             i_wen,
  input  port_t            i_lport,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  logic  [N_CH-1:0] r_en;
  port_t            r_port [N_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en <= '0;
      for (int i = 0; i < N_CH; i++) r_port[i] <= '0;
    end else if (i_we && int'(i_widx) < N_CH) begin
      r_en[i_widx]   <= i_wen;
      r_port[i_widx] <= i_wport;
    end
  end

  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_en[i] && r_port[i] == i_lport) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/udp_port_dispatcher.sv
// UDP receive dispatcher: parses the header, matches the
// destination port and steers payload to one channel.
module udp_port_dispatcher
  import eth_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 16,
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  byte_t            ip_data_in,
  input  logic             ip_byte_valid,
  input  logic             ip_eof,
  input  logic             ip_err,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  port_t            cfg_port,
  input  logic             cfg_en,
  output byte_t            udp_data_out,
  output logic [N_CH-1:0]  udp_byte_valid,
  output logic [N_CH-1:0]  udp_eof,
  output logic [N_CH-1:0]  udp_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  udp_disp_state_t  r_state, w_state;
  logic [2:0]       r_hdr_cnt, w_hdr_cnt;
  byte_t            r_dst_msb;
  port_t            r_len;
  logic             r_hit;
  logic [IDX_W-1:0] r_ch;
  port_t            r_exp, w_exp;
  port_t            r_pay_cnt, w_pay_cnt;
  logic             r_err_iss, w_err_iss;

  byte_t            r_data;
  logic [N_CH-1:0]  r_v, r_eof, r_err;
  logic [CNT_W-1:0] r_fcnt, r_dcnt;

  logic             w_fwd, w_eof, w_err;
  logic             w_finc, w_dinc;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic [N_CH-1:0]  w_oh;
  port_t            w_cnt1;
  logic             w_len_ok;

  udp_port_table #(.N_CH(N_CH)) u_tbl (
    .clk     (clk),
    .rst     (rst),
    .i_we    (cfg_we),
    .i_widx  (cfg_idx),
    .i_wport (cfg_port),
    .i_wen   (cfg_en),
    .i_lport ({r_dst_msb, ip_data_in}),
    .o_hit   (w_hit),
    .o_idx   (w_idx)
  );

  assign w_oh     = N_CH'(1) << r_ch;
  assign w_cnt1   = r_pay_cnt + 16'd1;
  assign w_len_ok = r_len >= 16'(UDP_HDR_LEN);

  always_comb begin
    w_state   = r_state;
    w_hdr_cnt = r_hdr_cnt;
    w_exp     = r_exp;
    w_pay_cnt = r_pay_cnt;
    w_err_iss = r_err_iss;
    w_fwd     = 1'b0;
    w_eof     = 1'b0;
    w_err     = 1'b0;
    w_finc    = 1'b0;
    w_dinc    = 1'b0;
    if (ip_byte_valid) begin
      unique case (r_state)
        HDR: begin
          w_hdr_cnt = r_hdr_cnt + 3'd1;
          if (r_hdr_cnt == 3'd7) begin
            w_hdr_cnt = '0;
            w_exp     = r_len - 16'(UDP_HDR_LEN);
            w_pay_cnt = '0;
            w_err_iss = 1'b0;
            if (ip_eof) begin
              if (r_hit && w_len_ok) begin
                w_eof  = !ip_err && r_len == 16'(UDP_HDR_LEN);
                w_err  = !w_eof;
                w_finc = w_eof;
              end else begin
                w_dinc = 1'b1;
              end
            end else if (r_hit && w_len_ok && !ip_err) begin
              w_state = PAYLOAD;
            end else begin
              w_state = DROP;
            end
          end else if (ip_eof || ip_err) begin
            w_hdr_cnt = '0;
            w_dinc    = 1'b1;
          end
        end
        PAYLOAD: begin
          w_fwd     = 1'b1;
          w_pay_cnt = w_cnt1;
          if (ip_eof) begin
            w_err   = ip_err || w_cnt1 != r_exp;
            w_eof   = !w_err;
            w_finc  = w_eof;
            w_state = HDR;
          end else if (ip_err) begin
            w_err     = 1'b1;
            w_err_iss = 1'b1;
            w_state   = DROP;
          end
        end
        DROP: begin
          if (ip_eof) begin
            w_dinc    = !r_err_iss;
            w_err_iss = 1'b0;
            w_state   = HDR;
          end
        end
        default: w_state = HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= HDR;
      r_hdr_cnt <= '0;
      r_dst_msb <= '0;
      r_len     <= '0;
      r_hit     <= 1'b0;
      r_ch      <= '0;
      r_exp     <= '0;
      r_pay_cnt <= '0;
      r_err_iss <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_hdr_cnt <= w_hdr_cnt;
      r_exp     <= w_exp;
      r_pay_cnt <= w_pay_cnt;
      r_err_iss <= w_err_iss;
      if (ip_byte_valid && r_state == HDR) begin
        if (r_hdr_cnt == 3'(UDP_DST_MSB))
          r_dst_msb <= ip_data_in;
        if (r_hdr_cnt == 3'(UDP_DST_MSB + 1)) begin
          r_hit <= w_hit;
          r_ch  <= w_idx;
        end
        if (r_hdr_cnt == 3'(UDP_LEN_MSB))
          r_len[15:8] <= ip_data_in;
        if (r_hdr_cnt == 3'(UDP_LEN_MSB + 1))
          r_len[7:0] <= ip_data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_v    <= '0;
      r_eof  <= '0;
      r_err  <= '0;
      r_fcnt <= '0;
      r_dcnt <= '0;
    end else begin
      if (w_fwd) r_data <= ip_data_in;
      r_v   <= w_fwd ? w_oh : '0;
      r_eof <= w_eof ? w_oh : '0;
      r_err <= w_err ? w_oh : '0;
      if (w_finc && r_fcnt != '1) r_fcnt <= r_fcnt + CNT_W'(1);
      if (w_dinc && r_dcnt != '1) r_dcnt <= r_dcnt + CNT_W'(1);
    end
  end

  assign udp_data_out   = r_data;
  assign udp_byte_valid = r_v;
  assign udp_eof        = r_eof;
  assign udp_err        = r_err;
  assign frame_cnt      = r_fcnt;
  assign drop_cnt       = r_dcnt;

endmodule
